fns_cac_iter_coder: RTL and testbench

Parametrised, iterative Fibonacci-numeral-system (FNS) crosstalk-avoidance encoder. It converts a binary data word into a CW-bit TSV codeword using greedy MSB-first digit selection. Each codeword bit has its own runtime threshold and weight, so local/adjusted FNS variants are supported. Per-bit enable masking covers disabled or faulty TSVs. The block sits between the data source and the TSV driver register and uses valid/ready handshakes on both sides.

---
 rtl/fns_cac_pkg.sv | 26 ++
 rtl/fns_bit_step.sv | 33 +++
 rtl/fns_cac_iter_coder.sv | 168 ++++++++++++++++
 tb/tb_fns_cac_iter_coder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fns_cac_pkg.sv
// Shared definitions for the FNS crosstalk-avoidance coder.
// Contents:
//   state_e          - controller state encoding
//   FNS02..FNS05     - leading Fibonacci-numeral-system weights
//   THR_DEF, WGT_DEF - default per-bit threshold/weight vectors for CW=5, DW=4
//                      (bit i occupies [i*4 +: 4]; literal order is bit 4 down to bit 0)
package fns_cac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FNS02 = 1;
    localparam int FNS03 = 2;
    localparam int FNS04 = 3;
    localparam int FNS05 = 5;

    localparam int CW_DEF = 5;
    localparam int DW_DEF = 4;

    localparam logic [CW_DEF*DW_DEF-1:0] THR_DEF = {4'd5, 4'd5, 4'd2, 4'd2, 4'd1};
    localparam logic [CW_DEF*DW_DEF-1:0] WGT_DEF = {4'd5, 4'd3, 4'd2, 4'd1, 4'd1};

endpackage : fns_cac_pkg

// File: rtl/fns_bit_step.sv
// One greedy digit decision of the FNS coder (purely combinational).
// Ports:
//   r_i      - current residual
//   thr_i    - compare threshold for this bit
//   wgt_i    - weight subtracted when the bit is set
//   en_i     - bit enable; a disabled bit never sets
//   bit_o    - decided codeword bit
//   r_next_o - residual after this bit
//   sat_o    - bit set but weight exceeds residual; residual clamps to 0
module fns_bit_step #(
    parameter int DW = 4
) (
    input  logic [DW-1:0] r_i,
    input  logic [DW-1:0] thr_i,
    input  logic [DW-1:0] wgt_i,
    input  logic          en_i,
    output logic          bit_o,
    output logic [DW-1:0] r_next_o,
    output logic          sat_o
);

    always_comb begin
        bit_o    = en_i & (r_i >= thr_i);
        sat_o    = bit_o & (wgt_i > r_i);
        r_next_o = r_i;
        if (bit_o) begin
            // Clamp instead of wrapping so an underflow cannot masquerade
            // as a large legitimate residual.
            r_next_o = sat_o ? '0 : (r_i - wgt_i);
        end
    end

endmodule : fns_bit_step

// File: rtl/fns_cac_iter_coder.sv
// Iterative FNS crosstalk-avoidance encoder: one codeword bit per cycle,
// MSB first, with runtime per-bit thresholds, weights and enables.
// Ports:
//   clock_i, rst_ni           - clock, async active-low reset
//   in_valid_i / in_ready_o   - input handshake (ready only in IDLE)
//   datain_i                  - binary word to encode
//   en_flag_i, thr_i, wgt_i   - per-bit enable, threshold, weight (snapshotted on accept)
//   out_valid_o / out_ready_i - output handshake (valid only in DONE)
//   codeout_o                 - codeword, updated only on entry to DONE
//   err_o                     - word not representable; qualified by out_valid_o
module fns_cac_iter_coder
    import fns_cac_pkg::*;
#(
    parameter int CW = 5,
    parameter int DW = 4
) (
    input  logic             clock_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    datain_i,
    input  logic [CW-1:0]    en_flag_i,
    input  logic [CW*DW-1:0] thr_i,
    input  logic [CW*DW-1:0] wgt_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CW-1:0]    codeout_o,
    output logic             err_o
);

    localparam int IDX_W = $clog2(CW);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CW - 1);

    state_e           state_q, state_d;
    logic [DW-1:0]    r_q, r_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CW-1:0]    code_q, code_d;
    logic [CW-1:0]    codeout_q, codeout_d;
    logic             err_q, err_d;
    logic [CW-1:0]    en_q, en_d;
    logic [CW*DW-1:0] thr_q, thr_d;
    logic [CW*DW-1:0] wgt_q, wgt_d;

    logic [DW-1:0]    thr_sel, wgt_sel;
    logic             en_sel;
    logic             step_bit, step_sat;
    logic [DW-1:0]    step_r;
    logic [CW-1:0]    code_upd;

    // Select the snapshot fields of the bit currently being decided.
    always_comb begin
        thr_sel = '0;
        wgt_sel = '0;
        en_sel  = 1'b0;
        for (int i = 0; i < CW; i++) begin
            if (idx_q == IDX_W'(i)) begin
                thr_sel = thr_q[i*DW +: DW];
                wgt_sel = wgt_q[i*DW +: DW];
                en_sel  = en_q[i];
            end
        end
    end

    fns_bit_step #(.DW(DW)) u_step (
        .r_i      (r_q),
        .thr_i    (thr_sel),
        .wgt_i    (wgt_sel),
        .en_i     (en_sel),
        .bit_o    (step_bit),
        .r_next_o (step_r),
        .sat_o    (step_sat)
    );

    always_comb begin
        code_upd = code_q;
        for (int i = 0; i < CW; i++) begin
            if (idx_q == IDX_W'(i)) begin
                code_upd[i] = step_bit;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        idx_d     = idx_q;
        code_d    = code_q;
        codeout_d = codeout_q;
        err_d     = err_q;
        en_d      = en_q;
        thr_d     = thr_q;
        wgt_d     = wgt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_d = ST_RUN;
                    r_d     = datain_i;
                    en_d    = en_flag_i;
                    thr_d   = thr_i;
                    wgt_d   = wgt_i;
                    code_d  = '0;
                    err_d   = 1'b0;
                    idx_d   = IDX_MAX;
                end
            end
            ST_RUN: begin
                r_d    = step_r;
                code_d = code_upd;
                if (step_sat) begin
                    err_d = 1'b1;
                end
                if (idx_q == '0) begin
                    state_d   = ST_DONE;
                    // Publish the full word only now so out_valid never
                    // coincides with partial bits.
                    codeout_d = code_upd;
                    if (step_r != '0) begin
                        err_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q       <= '0;
            idx_q     <= '0;
            code_q    <= '0;
            codeout_q <= '0;
            err_q     <= 1'b0;
            en_q      <= '0;
            thr_q     <= '0;
            wgt_q     <= '0;
        end else begin
            r_q       <= r_d;
            idx_q     <= idx_d;
            code_q    <= code_d;
            codeout_q <= codeout_d;
            err_q     <= err_d;
            en_q      <= en_d;
            thr_q     <= thr_d;
            wgt_q     <= wgt_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign codeout_o   = codeout_q;
    assign err_o       = err_q;

endmodule : fns_cac_iter_coder

// File: tb/tb_fns_cac_iter_coder.sv
// Directed bench for fns_cac_iter_coder (CW=5, DW=4).
module tb_fns_cac_iter_coder;
    import fns_cac_pkg::*;

    localparam int CW = 5;
    localparam int DW = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    datain;
    logic [CW-1:0]    en_flag;
    logic [CW*DW-1:0] thr;
    logic [CW*DW-1:0] wgt;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    codeout;
    logic             err;

    int n_chk = 0;
    int n_err = 0;

    fns_cac_iter_coder #(.CW(CW), .DW(DW)) dut (
        .clock_i     (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .datain_i    (datain),
        .en_flag_i   (en_flag),
        .thr_i       (thr),
        .wgt_i       (wgt),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .codeout_o   (codeout),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one word, wait for out_valid, capture, then accept it.
    // lat counts clock edges from the accept edge (inclusive) to out_valid.
    task automatic run_word(input logic [DW-1:0] d, input logic [CW-1:0] e,
                            input logic [CW*DW-1:0] t, input logic [CW*DW-1:0] w,
                            output logic [CW-1:0] c, output logic er, output int lat);
        @(negedge clk);
        datain   = d;
        en_flag  = e;
        thr      = t;
        wgt      = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        c  = codeout;
        er = err;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        string               tag;
        logic [DW-1:0]       d;
        logic [CW-1:0]       e;
        logic [CW*DW-1:0]    t;
        logic [CW*DW-1:0]    w;
        logic [CW-1:0]       exp_code;
        logic                exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [CW-1:0] c;
        logic          er;
        int            lat;
        logic [CW-1:0] hold_code;
        logic          hold_err;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        datain    = '0;
        en_flag   = '1;
        thr       = THR_DEF;
        wgt       = WGT_DEF;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_codeout", codeout, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;

        // Basic encode with latency check.
        run_word(4'd7, 5'b11111, THR_DEF, WGT_DEF, c, er, lat);
        chk("basic7_code", c, 5'b10100);
        chk("basic7_err", er, 0);
        chk("basic7_latency", lat, 6);
        chk("basic7_ready_after", in_ready, 1);

        vecs.push_back('{"max12", 4'd12, 5'b11111, THR_DEF, WGT_DEF, 5'b11111, 1'b0});
        vecs.push_back('{"over13", 4'd13, 5'b11111, THR_DEF, WGT_DEF, 5'b11111, 1'b1});
        vecs.push_back('{"zero", 4'd0, 5'b11111, THR_DEF, WGT_DEF, 5'b00000, 1'b0});
        vecs.push_back('{"mask10111", 4'd7, 5'b10111, THR_DEF, WGT_DEF, 5'b10100, 1'b0});
        vecs.push_back('{"mask01111", 4'd7, 5'b01111, THR_DEF, WGT_DEF, 5'b01111, 1'b0});
        vecs.push_back('{"mask00000", 4'd3, 5'b00000, THR_DEF, WGT_DEF, 5'b00000, 1'b1});
        vecs.push_back('{"saturate", 4'd4, 5'b01000,
                         {4'd5, 4'd2, 4'd2, 4'd2, 4'd1},
                         {4'd5, 4'd7, 4'd2, 4'd1, 4'd1}, 5'b01000, 1'b1});
        // Zero threshold on bit 0 always sets; zero weight leaves r alone.
        vecs.push_back('{"thr0_wgt0", 4'd0, 5'b00001,
                         {4'd5, 4'd5, 4'd2, 4'd2, 4'd0},
                         {4'd5, 4'd3, 4'd2, 4'd1, 4'd0}, 5'b00001, 1'b0});

        foreach (vecs[k]) begin
            run_word(vecs[k].d, vecs[k].e, vecs[k].t, vecs[k].w, c, er, lat);
            chk({vecs[k].tag, "_code"}, c, vecs[k].exp_code);
            chk({vecs[k].tag, "_err"}, er, vecs[k].exp_err);
            chk({vecs[k].tag, "_latency"}, lat, 6);
        end

        // Backpressure, with inputs disturbed during RUN.
        @(negedge clk);
        datain   = 4'd12;
        en_flag  = 5'b11111;
        thr      = THR_DEF;
        wgt      = WGT_DEF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        datain   = 4'd3;
        en_flag  = 5'b00000;
        @(negedge clk);
        chk("bp_ready_run", in_ready, 0);
        datain  = 4'd9;
        en_flag = 5'b10101;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_valid", out_valid, 1);
        chk("bp_code", codeout, 5'b11111);
        chk("bp_err", err, 0);
        hold_code = codeout;
        hold_err  = err;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_code", codeout, 5'b11111);
            chk("bp_hold_err", err, 0);
            chk("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_code_held_idle", codeout, 5'b11111);

        // Reset abort mid-RUN; prior codeout must clear asynchronously.
        @(negedge clk);
        datain   = 4'd13;
        en_flag  = 5'b11111;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_in_run", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_code", codeout, 0);
        chk("abort_err", err, 0);
        chk("abort_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_word(4'd7, 5'b11111, THR_DEF, WGT_DEF, c, er, lat);
        chk("post_abort_code", c, 5'b10100);
        chk("post_abort_err", er, 0);
        chk("post_abort_latency", lat, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_fns_cac_iter_coder
